// File: rtl/window_stream_arbiter.sv
// Round-robin packet arbiter merging N_PORTS beat streams into one, holding each grant for a whole window.
// Optional stream_last output is enabled by defining WINDOW_ARB_LAST_EN.
module window_stream_arbiter #(
  parameter int N_PORTS          = 4,
  parameter int BUS_WIDTH        = 128,
  parameter int BEATS_PER_WINDOW = 10
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [N_PORTS-1:0]                            in_valid,
  output logic [N_PORTS-1:0]                            in_ready,
  input  logic [N_PORTS*BUS_WIDTH-1:0]                  in_stream,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [BUS_WIDTH-1:0]                          out_stream,
  output logic [(N_PORTS > 1 ? $clog2(N_PORTS) : 1)-1:0] grant_port,
  output logic                                          busy
`ifdef WINDOW_ARB_LAST_EN
  ,
  output logic                                          stream_last
`endif
);

  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = (BEATS_PER_WINDOW > 1) ? $clog2(BEATS_PER_WINDOW) : 1;

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [GW-1:0]   ptr_after_grant;
  logic [GW-1:0]   search_base;
  logic [GW-1:0]   search_pick;
  logic            search_found;
  logic            last_beat;
  logic            handshake;

  assign ptr_after_grant = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + GW'(1);
  assign last_beat       = (beat_cnt_q == CW'(BEATS_PER_WINDOW - 1));

  // At a packet boundary the search starts just past the finishing port, so it is only regranted when alone.
  always_comb begin
    search_found = 1'b0;
    search_pick  = '0;
    search_base  = (state_q == LOCK) ? ptr_after_grant : rr_ptr_q;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!search_found && in_valid[i] && (GW'(i) >= search_base)) begin
        search_found = 1'b1;
        search_pick  = GW'(i);
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (!search_found && in_valid[i]) begin
        search_found = 1'b1;
        search_pick  = GW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    out_valid  = 1'b0;
    in_ready   = '0;
    out_stream = '0;
    handshake  = 1'b0;
    case (state_q)
      IDLE: begin
        if (search_found) begin
          state_d = LOCK;
          grant_d = search_pick;
        end
      end
      LOCK: begin
        out_valid          = in_valid[grant_q];
        in_ready[grant_q]  = out_ready;
        out_stream         = in_stream[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH];
        handshake          = out_valid && out_ready;
        if (handshake) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            rr_ptr_d   = ptr_after_grant;
            if (search_found) begin
              grant_d = search_pick;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_port = grant_q;
  assign busy       = (state_q == LOCK);

`ifdef WINDOW_ARB_LAST_EN
  assign stream_last = (state_q == LOCK) && out_valid && last_beat;
`endif

endmodule

// File: tb/tb_window_stream_arbiter.sv
// Scoreboard bench for window_stream_arbiter: expected beats are queued per packet and popped on each output handshake.
module tb_window_stream_arbiter;

  localparam int N = 4;
  localparam int W = 128;
  localparam int B = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_stream;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_stream;
  logic [1:0]     grant_port;
  logic           busy;
`ifdef WINDOW_ARB_LAST_EN
  logic           stream_last;
`endif

  typedef struct {
    int port;
    int idx;
    bit last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          src_cnt[N];
  int          plan_cnt[N];
  int          remaining[N];
  logic [N-1:0] gap;

  window_stream_arbiter #(
    .N_PORTS(N),
    .BUS_WIDTH(W),
    .BEATS_PER_WINDOW(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_stream(in_stream),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_stream(out_stream),
    .grant_port(grant_port),
    .busy(busy)
`ifdef WINDOW_ARB_LAST_EN
    ,
    .stream_last(stream_last)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] make_beat(input int p, input int k);
    logic [7:0]  pb;
    logic [23:0] kb;
    pb = p[7:0];
    kb = k[23:0];
    return {pb, kb, 32'hC0DE_0000 ^ k, p * 7919 + k * 31, 32'hDEAD_BEEF ^ (k << p)};
  endfunction

  // Sink-side scoreboard: every output handshake must match the oldest queued beat.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL extra_beat: port %0d delivered a beat, required none", grant_port);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (out_stream !== make_beat(mon_e.port, mon_e.idx)) begin
          errors++;
          $display("[TB] FAIL beat_data: got %h, required %h (port %0d beat %0d)",
                   out_stream, make_beat(mon_e.port, mon_e.idx), mon_e.port, mon_e.idx);
        end
        checks++;
        if (grant_port !== 2'(mon_e.port)) begin
          errors++;
          $display("[TB] FAIL beat_grant: got %0d, required %0d", grant_port, mon_e.port);
        end
`ifdef WINDOW_ARB_LAST_EN
        checks++;
        if (stream_last !== mon_e.last) begin
          errors++;
          $display("[TB] FAIL stream_last: got %b, required %b (port %0d beat %0d)",
                   stream_last, mon_e.last, mon_e.port, mon_e.idx);
        end
`endif
      end
    end
`ifdef WINDOW_ARB_LAST_EN
    if (out_valid !== 1'b1) begin
      checks++;
      if (stream_last !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stream_last_idle: got %b, required 0", stream_last);
      end
    end
`endif
  end

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      in_valid[p]        = (remaining[p] > 0) && !gap[p];
      in_stream[p*W +: W] = make_beat(p, src_cnt[p]);
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (acc[p]) begin
        src_cnt[p]++;
        remaining[p]--;
      end
    end
    drive_inputs();
  endtask

  task automatic push_packet(input int p);
    for (int i = 0; i < B; i++) begin
      sb.push_back('{port: p, idx: plan_cnt[p] + i, last: (i == B - 1)});
    end
    plan_cnt[p] += B;
  endtask

  task automatic wait_drain(input int budget, input string name, output int n);
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: %0d beats outstanding after %0d cycles, required 0", name, sb.size(), n);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    out_ready = 1'b0;
    gap       = '0;
    for (int p = 0; p < N; p++) remaining[p] = 0;
    drive_inputs();
    step();
    step();
    sb.delete();
    for (int p = 0; p < N; p++) plan_cnt[p] = src_cnt[p];
    rst = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    for (int p = 0; p < N; p++) remaining[p] = B;
    rst = 1'b0;
    drive_inputs();
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, required 0000", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (grant_port !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant: got %0d, required 0", grant_port); end
    checks++; if (out_stream !== '0) begin errors++; $display("[TB] FAIL reset_out_stream: got %h, required 0", out_stream); end
    for (int p = 0; p < N; p++) remaining[p] = 0;
    drive_inputs();
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single_requester();
    int n;
    push_packet(2);
    remaining[2] = B;
    out_ready = 1'b1;
    drive_inputs();
    step();
    checks++; if (grant_port !== 2'd2) begin errors++; $display("[TB] FAIL single_grant: got %0d, required 2", grant_port); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b, required 1", busy); end
    wait_drain(100, "single", n);
    checks++; if (n + 1 != 1 + B) begin errors++; $display("[TB] FAIL single_cycles: got %0d, required %0d", n + 1, 1 + B); end
    repeat (3) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_after: out_valid got %b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int n;
    remaining[0] = 2 * B;
    for (int p = 1; p < N; p++) remaining[p] = B;
    push_packet(0);
    push_packet(1);
    push_packet(2);
    push_packet(3);
    push_packet(0);
    out_ready = 1'b1;
    drive_inputs();
    wait_drain(200, "b2b", n);
    checks++; if (n != 1 + 5 * B) begin errors++; $display("[TB] FAIL b2b_cycles: got %0d, required %0d", n, 1 + 5 * B); end
  endtask

  task automatic test_backpressure();
    int c;
    remaining[1] = B;
    push_packet(1);
    drive_inputs();
    c = 0;
    while (sb.size() != 0 && c < 100) begin
      out_ready = (c % 2 == 0);
      #1;
      if (busy === 1'b1 && out_ready == 1'b0) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid: got %b, required 1", out_valid); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_in_ready: got %b, required 0000", in_ready); end
        checks++;
        if (out_stream !== make_beat(1, src_cnt[1])) begin
          errors++;
          $display("[TB] FAIL bp_hold: got %h, required %h", out_stream, make_beat(1, src_cnt[1]));
        end
      end
      step();
      c++;
    end
    checks++; if (c != 1 + 2 * B) begin errors++; $display("[TB] FAIL bp_cycles: got %0d, required %0d", c, 1 + 2 * B); end
  endtask

  task automatic test_source_gap();
    int n;
    bit gap_done;
    remaining[0] = B;
    remaining[3] = B;
    push_packet(0);
    push_packet(3);
    out_ready = 1'b1;
    drive_inputs();
    n = 0;
    gap_done = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      if (!gap_done && src_cnt[0] == plan_cnt[0] - B + 5) begin
        gap[0] = 1'b1;
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
          #1;
          checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL gap_out_valid: got %b, required 0", out_valid); end
          checks++; if (grant_port !== 2'd0) begin errors++; $display("[TB] FAIL gap_grant: got %0d, required 0", grant_port); end
          checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL gap_busy: got %b, required 1", busy); end
          checks++; if (in_ready[3] !== 1'b0) begin errors++; $display("[TB] FAIL gap_port3_ready: got %b, required 0", in_ready[3]); end
          step();
          n++;
        end
        gap[0] = 1'b0;
        drive_inputs();
        gap_done = 1'b1;
      end else begin
        step();
        n++;
      end
    end
    checks++; if (gap_done !== 1'b1) begin errors++; $display("[TB] FAIL gap_reached: got %b, required 1", gap_done); end
    checks++; if (n != 1 + 2 * B + 3) begin errors++; $display("[TB] FAIL gap_cycles: got %0d, required %0d", n, 1 + 2 * B + 3); end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    int target;
    remaining[1] = 2 * B;
    push_packet(1);
    push_packet(1);
    out_ready = 1'b1;
    drive_inputs();
    target = src_cnt[1] + B + 6;
    n = 0;
    while (src_cnt[1] != target && n < 100) begin
      step();
      n++;
    end
    checks++; if (src_cnt[1] != target) begin errors++; $display("[TB] FAIL mid_reach: got %0d beats, required %0d", src_cnt[1], target); end
    out_ready = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b, required 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL mid_in_ready: got %b, required 0000", in_ready); end
    checks++; if (grant_port !== 2'd0) begin errors++; $display("[TB] FAIL mid_grant: got %0d, required 0", grant_port); end
    checks++; if (sb.size() != B - 6) begin errors++; $display("[TB] FAIL mid_delivered: got %0d outstanding, required %0d", sb.size(), B - 6); end
    sb.delete();
    for (int p = 0; p < N; p++) plan_cnt[p] = src_cnt[p];
    remaining[1] = B;
    remaining[3] = B;
    rst = 1'b1;
    out_ready = 1'b1;
    push_packet(1);
    push_packet(3);
    drive_inputs();
    step();
    checks++; if (grant_port !== 2'd1) begin errors++; $display("[TB] FAIL mid_regrant: got %0d, required 1", grant_port); end
    wait_drain(200, "mid", n);
  endtask

  initial begin
    rst       = 1'b0;
    out_ready = 1'b0;
    gap       = '0;
    for (int p = 0; p < N; p++) begin
      src_cnt[p]   = 0;
      plan_cnt[p]  = 0;
      remaining[p] = 0;
    end
    drive_inputs();
    @(posedge clk);
    #1;
    $display("[TB] starting window_stream_arbiter tests");
    test_reset();
    test_single_requester();
    do_reset();
    test_back_to_back();
    do_reset();
    test_backpressure();
    do_reset();
    test_source_gap();
    do_reset();
    test_reset_mid_packet();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_stream_arbiter.md
WINDOW_STREAM_ARBITER -- requirements
Module: window_stream_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of serializer streams, one per pyramid level, legal range 1..8.
REQ-002 SHALL have parameter BUS_WIDTH, default 128: beat width; each beat is 124 data bits plus 4 metadata bits.
REQ-003 SHALL have parameter BEATS_PER_WINDOW, default 10: beats per window packet (1152 bits / 124 rounded up), legal range 1..255.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, N_PORTS: per-port beat valid.
REQ-007 SHALL have port in_ready, output, N_PORTS: per-port beat accept.
REQ-008 SHALL have port in_stream, input, N_PORTS*BUS_WIDTH: port p's beat is at slice [p*BUS_WIDTH +: BUS_WIDTH].
REQ-009 SHALL have port out_valid, output, 1: merged stream valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accept.
REQ-011 SHALL have port out_stream, output, BUS_WIDTH: merged beat.
REQ-012 SHALL have port grant_port, output, $clog2(N_PORTS) (minimum 1): index of the port currently owning the output.
REQ-013 SHALL have port busy, output, 1: high while in state LOCK.

Function
REQ-014 SHALL use two states: IDLE and LOCK.
REQ-015 In IDLE, out_valid and all in_ready SHALL be 0, and out_stream SHALL be 0.
REQ-016 In IDLE with any in_valid high, the next state SHALL be LOCK, with grant set to the first requesting port found searching upward from rr_ptr with wrap (latency 1 cycle).
REQ-017 In LOCK, out_valid SHALL equal in_valid[grant] and in_ready[grant] SHALL equal out_ready; all other in_ready SHALL be 0; out_stream SHALL be the grant slice (combinational pass-through).
REQ-018 The beat handshake SHALL be defined as out_valid && out_ready; beat_cnt SHALL increment on each handshake only.
REQ-019 Grant SHALL stay locked for exactly BEATS_PER_WINDOW handshakes; no re-arbitration mid-packet, even if in_valid[grant] drops (output stalls).
REQ-020 On the final handshake (beat_cnt == BEATS_PER_WINDOW-1):
- beat_cnt SHALL return to 0 and rr_ptr SHALL become (grant+1) mod N_PORTS.
- The arbiter SHALL search from the new rr_ptr over the same-cycle in_valid.
- If any port is requesting, it SHALL stay in LOCK with the new grant (no bubble); otherwise it SHALL go to IDLE.
REQ-021 The just-finished port SHALL be regranted only if it is the sole requester (wrap search).
REQ-022 With N_PORTS=1, packets SHALL pass back-to-back with grant_port fixed at 0.
REQ-023 Beats SHALL never be dropped, duplicated or reordered; packet interleaving across ports is forbidden.

Reset
REQ-024 While rst=0 at a clock edge, the block SHALL enter state IDLE with grant=0, rr_ptr=0 and beat_cnt=0; outputs SHALL be out_valid=0, in_ready=0, busy=0, grant_port=0 and out_stream=0.
REQ-025 A reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from port 0.

Configuration
REQ-026 Macro WINDOW_ARB_LAST_EN SHALL control the stream_last output (1 bit).
- With the macro defined, stream_last SHALL be high with out_valid during LOCK when beat_cnt == BEATS_PER_WINDOW-1, and 0 at reset and in IDLE.
- Without the macro, the port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-027 Single requester: port 2 valid, out_ready=1 -> grant_port=2 one cycle later, 10 consecutive beats with data equal to port 2's slices, then IDLE.
REQ-028 All 4 ports continuously valid, out_ready=1 -> grants in order 0,1,2,3,0, each exactly 10 beats, with no idle cycle between packets.
REQ-029 Backpressure: out_ready toggled 1,0,1,0 during a port 1 packet -> beat_cnt advances only on handshake cycles, data held stable while stalled, 10 beats delivered.
REQ-030 Source gap: in_valid[0] drops for 3 cycles after beat 4 -> out_valid=0 for those 3 cycles, grant stays 0, port 3 is not granted despite requesting; beats 5..9 follow.
REQ-031 Reset (rst=0) at beat 6 of port 1 -> next cycle IDLE, busy=0, out_valid=0; with ports 1 and 3 requesting after release, port 1 is granted first (rr_ptr=0).
REQ-032 WINDOW_ARB_LAST_EN defined -> stream_last high only on the 10th beat of every packet, including back-to-back packets.
